usb_rx_pkt_decoder: RTL

- Receive-side packet decoder directly upstream of the control endpoint 0 handler.
- Consumes the byte stream from the bit-unstuff/NRZI layer (sop/eop-framed bytes) and validates the PID check nibble, CRC5 on tokens and CRC16 on data packets.
- Filters tokens by device address, strips the CRC16 from data payloads, and presents the rx_* packet interface that endpoint 0 consumes.

---
 rtl/usb_defs_pkg.sv | 38 +++
 rtl/usb_rx_pkt_decoder_if.sv | 31 +++
 rtl/usb_crc_byte.sv | 35 +++
 rtl/usb_rx_pkt_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_defs_pkg.sv
// Shared USB receive definitions: PID codes, decoder states, CRC constants, output bundle.
package usb_defs_pkg;

  localparam logic [3:0] PidOut   = 4'h1;
  localparam logic [3:0] PidIn    = 4'h9;
  localparam logic [3:0] PidSof   = 4'h5;
  localparam logic [3:0] PidSetup = 4'hD;
  localparam logic [3:0] PidData0 = 4'h3;
  localparam logic [3:0] PidData1 = 4'hB;
  localparam logic [3:0] PidAck   = 4'h2;
  localparam logic [3:0] PidNak   = 4'hA;
  localparam logic [3:0] PidStall = 4'hE;

  localparam logic [4:0]  Crc5Poly      = 5'b00101;
  localparam logic [4:0]  Crc5Preset    = 5'b11111;
  localparam logic [4:0]  Crc5Residual  = 5'b01100;
  localparam logic [15:0] Crc16Poly     = 16'h8005;
  localparam logic [15:0] Crc16Preset   = 16'hFFFF;
  localparam logic [15:0] Crc16Residual = 16'h800D;

  typedef enum logic [2:0] {StIdle, StTok1, StTok2, StData, StDiscard} state_e;

  // Registered rx_* outputs, kept together so reset and per-cycle pulse clearing stay simple.
  typedef struct packed {
    logic        valid;
    logic [3:0]  pid;
    logic [3:0]  data_pid;
    logic [6:0]  addr;
    logic [3:0]  ep;
    logic [10:0] frame;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [15:0] data_len;
    logic        crc_err;
    logic        pid_err;
  } rx_out_t;

endpackage

// File: rtl/usb_rx_pkt_decoder_if.sv
// Byte-stream input and rx_* packet output bundle of the receive packet decoder.
interface usb_rx_pkt_decoder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_sop;
  logic        in_eop;
  logic [6:0]  dev_addr;
  logic        rx_valid;
  logic [3:0]  rx_pid;
  logic [3:0]  rx_data_pid;
  logic [6:0]  rx_addr;
  logic [3:0]  rx_ep;
  logic [10:0] rx_frame;
  logic [7:0]  rx_data_in;
  logic        rx_data_valid;
  logic [15:0] rx_data_len;
  logic        rx_crc_err;
  logic        rx_pid_err;

  modport master (
    output in_valid, in_data, in_sop, in_eop, dev_addr,
    input  rx_valid, rx_pid, rx_data_pid, rx_addr, rx_ep, rx_frame,
    input  rx_data_in, rx_data_valid, rx_data_len, rx_crc_err, rx_pid_err
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, dev_addr,
    output rx_valid, rx_pid, rx_data_pid, rx_addr, rx_ep, rx_frame,
    output rx_data_in, rx_data_valid, rx_data_len, rx_crc_err, rx_pid_err
  );
endinterface

// File: rtl/usb_crc_byte.sv
// Byte-serial CRC, LSB first, with synchronous clear to the preset value.
module usb_crc_byte #(
  parameter int unsigned      Width  = 5,
  parameter logic [Width-1:0] Poly   = '0,
  parameter logic [Width-1:0] Preset = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  output logic [Width-1:0] o_crc_nxt
);

  logic [Width-1:0] r_crc;
  logic [Width-1:0] w_step;

  // Eight serial LFSR steps; o_crc_nxt is the CRC including the byte on i_data.
  always_comb begin
    w_step = r_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_step[Width-1] ^ i_data[i]) w_step = {w_step[Width-2:0], 1'b0} ^ Poly;
      else                             w_step = {w_step[Width-2:0], 1'b0};
    end
  end

  assign o_crc_nxt = w_step;

  // CRC register: preset on reset/clear, advance one byte per valid.
  always_ff @(posedge clk) begin
    if (rst || i_clear) r_crc <= Preset;
    else if (i_valid)   r_crc <= w_step;
  end

endmodule

// File: rtl/usb_rx_pkt_decoder.sv
// USB receive packet decoder: PID/CRC checks, token address filter, payload CRC strip.
module usb_rx_pkt_decoder
  import usb_defs_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter bit          ADDR_FILTER = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  usb_rx_pkt_decoder_if.slave bus
);

  localparam logic [15:0] MaxRcv = 16'(MAX_PAYLOAD + 2);

  state_e      r_state, w_state_nxt;
  rx_out_t     r_out, w_out_nxt;
  logic [3:0]  r_tok_pid, w_tok_pid_nxt;
  logic [7:0]  r_tok_b1, w_tok_b1_nxt;
  logic        r_armed, w_armed_nxt;
  logic [7:0]  r_buf0, w_buf0_nxt, r_buf1, w_buf1_nxt;
  logic [1:0]  r_buf_cnt, w_buf_cnt_nxt;
  logic [15:0] r_len, w_len_nxt, r_rcv, w_rcv_nxt;
  logic        r_err_eop, w_err_eop_nxt;

  logic        w_crc_clear, w_crc_feed, w_pid_ok;
  logic [3:0]  w_pid;
  logic [4:0]  w_crc5_nxt;
  logic [15:0] w_crc16_nxt;

  assign w_pid       = bus.in_data[3:0];
  assign w_pid_ok    = (bus.in_data[7:4] == ~bus.in_data[3:0]);
  assign w_crc_clear = bus.in_valid & bus.in_sop;
  assign w_crc_feed  = bus.in_valid & ~bus.in_sop;

  usb_crc_byte #(.Width(5), .Poly(Crc5Poly), .Preset(Crc5Preset)) u_crc5 (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_crc_clear),
    .i_valid   (w_crc_feed),
    .i_data    (bus.in_data),
    .o_crc_nxt (w_crc5_nxt)
  );

  usb_crc_byte #(.Width(16), .Poly(Crc16Poly), .Preset(Crc16Preset)) u_crc16 (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_crc_clear),
    .i_valid   (w_crc_feed),
    .i_data    (bus.in_data),
    .o_crc_nxt (w_crc16_nxt)
  );

  // Next-state and output decode; a sop byte always restarts parsing from the PID.
  always_comb begin
    w_state_nxt        = r_state;
    w_out_nxt          = r_out;
    w_out_nxt.valid      = 1'b0;
    w_out_nxt.data_valid = 1'b0;
    w_out_nxt.crc_err    = 1'b0;
    w_out_nxt.pid_err    = 1'b0;
    w_tok_pid_nxt      = r_tok_pid;
    w_tok_b1_nxt       = r_tok_b1;
    w_armed_nxt        = r_armed;
    w_buf0_nxt         = r_buf0;
    w_buf1_nxt         = r_buf1;
    w_buf_cnt_nxt      = r_buf_cnt;
    w_len_nxt          = r_len;
    w_rcv_nxt          = r_rcv;
    w_err_eop_nxt      = r_err_eop;
    if (bus.in_valid && bus.in_sop) begin
      w_len_nxt     = '0;
      w_rcv_nxt     = '0;
      w_buf_cnt_nxt = '0;
      w_err_eop_nxt = 1'b0;
      w_tok_pid_nxt = w_pid;
      w_state_nxt   = bus.in_eop ? StIdle : StDiscard;
      if (!w_pid_ok) begin
        w_out_nxt.pid_err = 1'b1;
      end else begin
        case (w_pid)
          PidOut, PidIn, PidSof, PidSetup: begin
            if (bus.in_eop) begin
              // Truncated token counts as a CRC failure.
              w_out_nxt.valid   = 1'b1;
              w_out_nxt.crc_err = 1'b1;
              w_armed_nxt       = 1'b0;
            end else begin
              w_state_nxt = StTok1;
            end
          end
          PidData0, PidData1: begin
            if (r_armed) begin
              w_out_nxt.data_pid = w_pid;
              if (bus.in_eop) begin
                w_out_nxt.valid    = 1'b1;
                w_out_nxt.crc_err  = 1'b1;
                w_out_nxt.data_len = '0;
                w_armed_nxt        = 1'b0;
              end else begin
                w_state_nxt = StData;
              end
            end
          end
          PidAck, PidNak, PidStall: begin
            if (bus.in_eop) begin
              w_out_nxt.valid = 1'b1;
              w_out_nxt.pid   = w_pid;
            end
          end
          default: ;
        endcase
      end
    end else if (bus.in_valid) begin
      case (r_state)
        StTok1: begin
          w_tok_b1_nxt = bus.in_data;
          if (bus.in_eop) begin
            w_out_nxt.valid   = 1'b1;
            w_out_nxt.crc_err = 1'b1;
            w_armed_nxt       = 1'b0;
            w_state_nxt       = StIdle;
          end else begin
            w_state_nxt = StTok2;
          end
        end
        StTok2: begin
          w_state_nxt = StIdle;
          if (!bus.in_eop) begin
            // Overlong token: report as a CRC failure once the packet ends.
            w_armed_nxt   = 1'b0;
            w_err_eop_nxt = 1'b1;
            w_state_nxt   = StDiscard;
          end else if (w_crc5_nxt != Crc5Residual) begin
            w_out_nxt.valid   = 1'b1;
            w_out_nxt.crc_err = 1'b1;
            w_armed_nxt       = 1'b0;
          end else if (r_tok_pid == PidSof) begin
            w_out_nxt.valid = 1'b1;
            w_out_nxt.pid   = PidSof;
            w_out_nxt.frame = {bus.in_data[2:0], r_tok_b1};
          end else if (ADDR_FILTER && (r_tok_b1[6:0] != bus.dev_addr)) begin
            w_armed_nxt = 1'b0;
          end else begin
            w_out_nxt.valid = 1'b1;
            w_out_nxt.pid   = r_tok_pid;
            w_out_nxt.addr  = r_tok_b1[6:0];
            w_out_nxt.ep    = {bus.in_data[2:0], r_tok_b1[7]};
            // Only host-to-device tokens can be followed by a data packet for us.
            w_armed_nxt     = (r_tok_pid == PidOut) || (r_tok_pid == PidSetup);
          end
        end
        StData: begin
          w_rcv_nxt = r_rcv + 16'd1;
          if (r_rcv == MaxRcv) begin
            w_armed_nxt = 1'b0;
            if (bus.in_eop) begin
              w_out_nxt.valid    = 1'b1;
              w_out_nxt.crc_err  = 1'b1;
              w_out_nxt.data_len = r_len;
              w_state_nxt        = StIdle;
            end else begin
              w_err_eop_nxt = 1'b1;
              w_state_nxt   = StDiscard;
            end
          end else begin
            // Two-byte delay line: the last two bytes of the packet are the CRC16.
            if (r_buf_cnt == 2'd2) begin
              w_out_nxt.data_in    = r_buf0;
              w_out_nxt.data_valid = 1'b1;
              w_buf0_nxt           = r_buf1;
              w_buf1_nxt           = bus.in_data;
              w_len_nxt            = r_len + 16'd1;
            end else if (r_buf_cnt == 2'd1) begin
              w_buf1_nxt    = bus.in_data;
              w_buf_cnt_nxt = 2'd2;
            end else begin
              w_buf0_nxt    = bus.in_data;
              w_buf_cnt_nxt = 2'd1;
            end
            if (bus.in_eop) begin
              w_out_nxt.valid    = 1'b1;
              w_out_nxt.data_len = w_len_nxt;
              w_out_nxt.crc_err  = (w_crc16_nxt != Crc16Residual) || (r_buf_cnt == 2'd0);
              w_armed_nxt        = 1'b0;
              w_state_nxt        = StIdle;
            end
          end
        end
        StDiscard: begin
          if (bus.in_eop) begin
            w_state_nxt = StIdle;
            if (r_err_eop) begin
              w_out_nxt.valid    = 1'b1;
              w_out_nxt.crc_err  = 1'b1;
              w_out_nxt.data_len = r_len;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_out     <= '0;
      r_tok_pid <= '0;
      r_tok_b1  <= '0;
      r_armed   <= 1'b0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_buf_cnt <= '0;
      r_len     <= '0;
      r_rcv     <= '0;
      r_err_eop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_out     <= w_out_nxt;
      r_tok_pid <= w_tok_pid_nxt;
      r_tok_b1  <= w_tok_b1_nxt;
      r_armed   <= w_armed_nxt;
      r_buf0    <= w_buf0_nxt;
      r_buf1    <= w_buf1_nxt;
      r_buf_cnt <= w_buf_cnt_nxt;
      r_len     <= w_len_nxt;
      r_rcv     <= w_rcv_nxt;
      r_err_eop <= w_err_eop_nxt;
    end
  end

  assign bus.rx_valid      = r_out.valid;
  assign bus.rx_pid        = r_out.pid;
  assign bus.rx_data_pid   = r_out.data_pid;
  assign bus.rx_addr       = r_out.addr;
  assign bus.rx_ep         = r_out.ep;
  assign bus.rx_frame      = r_out.frame;
  assign bus.rx_data_in    = r_out.data_in;
  assign bus.rx_data_valid = r_out.data_valid;
  assign bus.rx_data_len   = r_out.data_len;
  assign bus.rx_crc_err    = r_out.crc_err;
  assign bus.rx_pid_err    = r_out.pid_err;

endmodule
